// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Transmit-side byte buffer placed directly in front of the UART serialiser.
// The CPU pushes bytes into a circular FIFO. The FIFO hands them to the
// serialiser one at a time over the tx_en / tx_status handshake, so software
// can queue a burst without polling the serialiser between characters.
// Everything runs in the br_clk_16 domain.
//
// Optional feature macro: UART_TX_FIFO_FLUSH_EN
//   When defined, the block gets a flush input. It empties the FIFO, but a
//   byte already handed to the serialiser is still sent.
//
// Ports
//   br_clk_16  in   16x baud clock; all state changes on its rising edge
//   reset      in   asynchronous, active-low
//   wr_en      in   push request
//   wr_data    in   byte to push
//   full       out  count == depth (combinational)
//   empty      out  count == 0 (combinational)
//   count      out  number of stored bytes (DEPTH_LOG2+1 bits)
//   overflow   out  sticky; set by a push attempted while full
//   ovf_clr    in   synchronous clear of overflow (a same-edge set wins)
//   flush      in   (UART_TX_FIFO_FLUSH_EN only) discard queued bytes
//   tx_status  in   serialiser status: 1 = idle/ready, 0 = shifting
//   tx_en      out  registered one-cycle start pulse to the serialiser
//   tx_data    out  registered byte for the serialiser; holds its last value
//   fsm_state  out  debug view of the hand-off state machine
//                   (0 = IDLE, 1 = WAIT_BUSY, 2 = WAIT_DONE)
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  br_clk_16,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  ovf_clr,
`ifdef UART_TX_FIFO_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  tx_status,
    output logic                  tx_en,
    output logic [7:0]            tx_data,
    output logic [1:0]            fsm_state
);

    localparam int                 DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = DEPTH[DEPTH_LOG2:0];

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;

    logic                  flush_req;
    logic                  push_ok;
    logic                  push_drop;
    logic                  pop;

`ifdef UART_TX_FIFO_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign fsm_state = state;

    // The full check uses the count from before the edge. A push while full
    // is dropped even if a pop frees a slot on the same edge. Flush wins over
    // push, but does not hide a push attempted while full from overflow.
    assign push_ok   = wr_en && !full && !flush_req;
    assign push_drop = wr_en && full;

    // Serialiser handshake:
    //   The FIFO offers a byte by pulsing tx_en for exactly one cycle, with
    //   tx_data valid in that same cycle. It does so only from IDLE while
    //   tx_status = 1. The serialiser takes the byte on the edge where it
    //   sees tx_en = 1 and drops tx_status while it shifts. The FIFO waits
    //   for tx_status to fall (WAIT_BUSY) and then rise again (WAIT_DONE)
    //   before it can offer the next byte. This guarantees no second start
    //   pulse lands inside a frame.

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge br_clk_16 or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_next = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!tx_status) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_status) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: decides whether this edge hands a byte over.
    // A flush on the same edge cancels the pop, so the FSM stays in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        pop = 1'b0;
        if (state == IDLE && !empty && tx_status && !flush_req) begin
            pop = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Storage. Contents need no reset; only pointers and count define
    // which entries are valid.
    // ------------------------------------------------------------------
    always_ff @(posedge br_clk_16) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, count, overflow and the registered serialiser outputs.
    // Pointers are exactly DEPTH_LOG2 bits wide, so depth-1 wraps to 0
    // on its own.
    // ------------------------------------------------------------------
    always_ff @(posedge br_clk_16 or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            tx_en    <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            if (flush_req) begin
                // Make the FIFO empty without touching rd_ptr. A byte that
                // was already popped is unaffected.
                wr_ptr <= rd_ptr;
                count  <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push_ok, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end

            if (push_drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end

            // tx_en is high only in the cycle after a pop. tx_data holds
            // its value until the next pop.
            tx_en <= pop;
            if (pop) begin
                tx_data <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Bench for uart_tx_fifo.
//
// A behavioural serialiser model starts a 10-bit frame whenever it sees
// tx_en while idle. The frame is a start bit, 8 data bits sent LSB first,
// and a stop bit, with 16 clocks per bit. A line decoder rebuilds each
// frame from uart_tx.
//
// Accepted bytes go onto exp_q when the bench drives them. Each tx_en pulse
// pops exp_q and compares tx_data against it, then forwards the expected
// byte to uart_q. Each decoded frame pops uart_q.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int BIT_CYC    = 16;
    localparam int FRAME_CYC  = 10 * BIT_CYC;

    // ---------------- clock / reset ----------------
    logic                br_clk_16 = 1'b0;
    logic                reset;
    always #5 br_clk_16 = ~br_clk_16;

    // ---------------- DUT signals ----------------
    logic                wr_en;
    logic [7:0]          wr_data;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic                ovf_clr;
    logic                tx_status;
    logic                tx_en;
    logic [7:0]          tx_data;
    logic [1:0]          fsm_state;
`ifdef UART_TX_FIFO_FLUSH_EN
    logic                flush;
`endif

    uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .br_clk_16 (br_clk_16),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
`ifdef UART_TX_FIFO_FLUSH_EN
        .flush     (flush),
`endif
        .tx_status (tx_status),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .fsm_state (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] uart_q[$];
    int         pulse_cnt  = 0;
    logic       prev_tx_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    // ---------------- serialiser model ----------------
    logic       ser_hold = 1'b0;   // forces tx_status low to stall hand-off
    logic       ser_busy = 1'b0;
    logic [9:0] ser_frame = '1;
    int         ser_bit  = 0;
    int         ser_tick = 0;
    logic       uart_tx  = 1'b1;

    assign tx_status = !ser_busy && !ser_hold;

    always @(posedge br_clk_16) begin
        if (!ser_busy) begin
            if (tx_en && tx_status) begin
                ser_busy  <= 1'b1;
                ser_frame <= {1'b1, tx_data, 1'b0};
                ser_bit   <= 0;
                ser_tick  <= 0;
                uart_tx   <= 1'b0;
            end
        end else begin
            if (ser_tick == BIT_CYC - 1) begin
                ser_tick <= 0;
                if (ser_bit == 9) begin
                    ser_busy <= 1'b0;
                    uart_tx  <= 1'b1;
                end else begin
                    ser_bit <= ser_bit + 1;
                    uart_tx <= ser_frame[ser_bit + 1];
                end
            end else begin
                ser_tick <= ser_tick + 1;
            end
        end
    end

    // ---------------- line decoder ----------------
    logic       rx_busy = 1'b0;
    int         rx_tick = 0;
    int         rx_bit  = 0;
    logic [9:0] rx_sh   = '0;

    always @(posedge br_clk_16) begin
        if (!rx_busy) begin
            if (uart_tx == 1'b0) begin
                rx_busy <= 1'b1;
                rx_tick <= 2;
                rx_bit  <= 0;
            end
        end else begin
            rx_tick <= rx_tick + 1;
            if (rx_tick == rx_bit * BIT_CYC + BIT_CYC / 2) begin
                if (rx_bit == 9) begin
                    rx_busy <= 1'b0;
                    check("uart_stop_bit", uart_tx, 1);
                    check("uart_frame_expected", uart_q.size() > 0, 1);
                    if (uart_q.size() > 0) begin
                        check("uart_byte", rx_sh[8:1], uart_q[0]);
                        void'(uart_q.pop_front());
                    end
                end else begin
                    rx_sh[rx_bit] <= uart_tx;
                    rx_bit        <= rx_bit + 1;
                end
            end
        end
    end

    // ---------------- tx_en monitor ----------------
    always @(negedge br_clk_16) begin
        prev_tx_en <= tx_en;
        if (tx_en === 1'b1) begin
            pulse_cnt++;
            check("tx_en_width", prev_tx_en, 0);
            check("tx_en_ser_idle", ser_busy, 0);
            if (exp_q.size() == 0) begin
                check("tx_en_spurious", tx_en, 0);
            end else begin
                check("tx_data", tx_data, exp_q[0]);
                uart_q.push_back(exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push(input logic [7:0] d, input logic accept);
        wr_en   = 1'b1;
        wr_data = d;
        if (accept) exp_q.push_back(d);
        @(negedge br_clk_16);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || uart_q.size() != 0 || ser_busy || rx_busy) && n < budget) begin
            @(negedge br_clk_16);
            n++;
        end
        repeat (3) @(negedge br_clk_16);
        check("drain_left", exp_q.size() + uart_q.size(), 0);
    endtask

    task automatic pulse_ovf_clr();
        ovf_clr = 1'b1;
        @(negedge br_clk_16);
        ovf_clr = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int p0;
        int n;
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        ovf_clr = 1'b0;
`ifdef UART_TX_FIFO_FLUSH_EN
        flush   = 1'b0;
`endif
        repeat (3) @(negedge br_clk_16);

        // Reset state
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_tx_en", tx_en, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_overflow", overflow, 0);
        check("rst_state", fsm_state, 0);
        reset = 1'b1;
        repeat (2) @(negedge br_clk_16);

        // Single byte: exact pulse latency
        p0 = pulse_cnt;
        push(8'hA5, 1'b1);
        check("t1_count_after_push", count, 1);
        check("t1_tx_en_edge_n", tx_en, 0);
        @(negedge br_clk_16);
        check("t1_tx_en_edge_n1", tx_en, 1);
        check("t1_tx_data", tx_data, 8'hA5);
        check("t1_count_after_pop", count, 0);
        check("t1_state_wait_busy", fsm_state, 1);
        @(negedge br_clk_16);
        check("t1_tx_en_edge_n2", tx_en, 0);
        check("t1_tx_data_hold", tx_data, 8'hA5);
        wait_idle(FRAME_CYC + 100);
        check("t1_pulses", pulse_cnt - p0, 1);

        // Three back-to-back bytes
        p0 = pulse_cnt;
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        push(8'h33, 1'b1);
        wait_idle(4 * FRAME_CYC);
        check("t2_pulses", pulse_cnt - p0, 3);

        // Fill with the serialiser stalled, then overflow
        p0 = pulse_cnt;
        ser_hold = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            push(8'($urandom_range(0, 255)), 1'b1);
        end
        check("t3_full", full, 1);
        check("t3_count_full", count, DEPTH);
        check("t3_overflow_clear", overflow, 0);
        check("t3_no_pop_stalled", tx_en, 0);
        push(8'hEE, 1'b0);
        check("t3_overflow_set", overflow, 1);
        check("t3_count_after_drop", count, DEPTH);
        pulse_ovf_clr();
        check("t3_overflow_cleared", overflow, 0);

        // Full: push dropped and pop on the same edge, then drain across wrap
        ser_hold = 1'b0;
        push(8'h5A, 1'b0);
        check("t4_count_15", count, DEPTH - 1);
        check("t4_overflow", overflow, 1);
        check("t4_not_full", full, 0);
        check("t4_tx_en", tx_en, 1);
        wait_idle((DEPTH + 1) * (FRAME_CYC + 10));
        check("t4_pulses", pulse_cnt - p0, DEPTH);
        check("t4_empty", empty, 1);
        pulse_ovf_clr();

        // Reset while in WAIT_DONE with 5 bytes queued
        p0 = pulse_cnt;
        for (int i = 0; i < 6; i++) begin
            push(8'($urandom_range(0, 255)), 1'b1);
        end
        n = 0;
        while (fsm_state != 2'd2 && n < 50) begin
            @(negedge br_clk_16);
            n++;
        end
        check("t5_in_wait_done", fsm_state, 2);
        check("t5_count_5", count, 5);
        reset = 1'b0;
        #1;
        check("t5_rst_count", count, 0);
        check("t5_rst_tx_en", tx_en, 0);
        check("t5_rst_empty", empty, 1);
        check("t5_rst_state", fsm_state, 0);
        exp_q.delete();
        @(negedge br_clk_16);
        reset = 1'b1;
        repeat (2 * FRAME_CYC) @(negedge br_clk_16);
        check("t5_no_tx_en_after_reset", pulse_cnt - p0, 1);
        wait_idle(FRAME_CYC);
        push(8'h3C, 1'b1);
        wait_idle(FRAME_CYC + 100);
        check("t5_new_push_pulses", pulse_cnt - p0, 2);

`ifdef UART_TX_FIFO_FLUSH_EN
        // Flush: in-flight byte completes, queued bytes vanish
        p0 = pulse_cnt;
        for (int i = 0; i < 4; i++) begin
            push(8'($urandom_range(0, 255)), 1'b1);
        end
        n = 0;
        while (pulse_cnt - p0 < 1 && n < 50) begin
            @(negedge br_clk_16);
            n++;
        end
        flush = 1'b1;
        exp_q.delete();
        @(negedge br_clk_16);
        flush = 1'b0;
        check("t6_flush_count", count, 0);
        check("t6_flush_empty", empty, 1);
        repeat (2 * FRAME_CYC) @(negedge br_clk_16);
        check("t6_flush_pulses", pulse_cnt - p0, 1);
        wait_idle(FRAME_CYC);
`endif

        // Random bytes with random gaps
        p0 = pulse_cnt;
        for (int i = 0; i < 12; i++) begin
            push(8'($urandom_range(0, 255)), 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge br_clk_16);
        end
        check("t7_no_overflow", overflow, 0);
        wait_idle(13 * (FRAME_CYC + 10));
        check("t7_pulses", pulse_cnt - p0, 12);
        check("t7_empty", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side byte buffer that sits directly upstream of the UART serialiser. Both blocks run in the br_clk_16 domain.
- Accepts bytes from the CPU peripheral bus, stores them in a circular FIFO, and hands them to the serialiser one at a time using the serialiser's TX_EN / TX_STATUS handshake.
- Lets software queue a burst of bytes without polling the serialiser between characters.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 entries of 8 bits.

Ports:
- br_clk_16  input  1  16x baud clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low.
- wr_en  input  1  push request, sampled each rising edge.
- wr_data  input  8  byte to push.
- full  output  1  combinational; count == depth.
- empty  output  1  combinational; count == 0.
- count  output  DEPTH_LOG2+1  number of stored bytes.
- overflow  output  1  sticky; set by a push attempted while full.
- ovf_clr  input  1  synchronous clear of overflow.
- tx_status  input  1  from serialiser; 1 = idle/ready, 0 = shifting.
- tx_en  output  1  registered one-cycle start pulse to serialiser.
- tx_data  output  8  registered byte to serialiser; stable from the tx_en cycle until the next pop.

Behaviour:
- Reset (asynchronous, reset=0) drives:
  - wr_ptr = rd_ptr = 0, count = 0.
  - tx_en = 0, tx_data = 8'h00, overflow = 0.
  - state = IDLE.
  - Memory contents are don't-care.
- A reset asserted mid-transfer discards all queued bytes. No tx_en is issued until a new push arrives after reset release.
- Push:
  - If wr_en=1 and full=0 at the edge: mem[wr_ptr] <= wr_data, wr_ptr increments modulo depth, count increments.
  - If wr_en=1 and full=1: the data is dropped, pointers and count are unchanged, overflow <= 1.
  - The full check uses the pre-edge count. A push while full is dropped even if a pop occurs on the same edge.
- overflow: ovf_clr=1 clears it. If ovf_clr and a dropped push occur on the same edge, set wins.
- Pop: occurs only in IDLE when empty=0 and tx_status=1. On that edge:
  - tx_data <= mem[rd_ptr];
  - rd_ptr increments modulo depth;
  - count decrements;
  - tx_en <= 1;
  - state -> WAIT_BUSY.
- Simultaneous push and pop (not full): count is unchanged and both pointers advance.
- Pointer wrap: ptr == depth-1 increments to 0. count never exceeds depth and never underflows.
- State machine:
  - IDLE: tx_en <= 0. Pops as above; otherwise stays in IDLE.
  - WAIT_BUSY: tx_en <= 0 (pulse width is exactly 1 cycle). Goes to WAIT_DONE when tx_status == 0; otherwise stays.
  - WAIT_DONE: goes to IDLE when tx_status == 1. Prevents a second tx_en before the serialiser finishes its frame.
- Latency: a byte pushed into an empty FIFO with the serialiser idle at edge N gives:
  - tx_en high during cycle N+1..N+2 (registered at edge N+1);
  - serialiser samples it at edge N+2;
  - tx_status low after N+2;
  - WAIT_DONE after N+3.
- Back-to-back bytes: the next pop happens on the first edge that sees tx_status=1 in IDLE, i.e. 2 edges after tx_status returns high.
- tx_data retains its last value between transfers.

Optional Feature:
- Macro: UART_TX_FIFO_FLUSH_EN.
- Enabled: adds input port flush (1 bit). On an edge with flush=1:
  - wr_ptr <= rd_ptr and count <= 0.
  - flush has priority over push and pop on that edge.
  - The byte already handed to the serialiser (WAIT_BUSY / WAIT_DONE) completes normally.
  - The state machine is not reset; overflow is not affected.
- Disabled: no flush port; the FIFO is emptied only by reset or by draining.

Test Plan:
- Reset then single push 8'hA5 with tx_status held 1:
  - tx_en pulses for exactly one cycle on the second edge after the push;
  - tx_data = 8'hA5;
  - count returns to 0.
- Push 3 bytes 8'h11, 8'h22, 8'h33 back-to-back while connected to the serialiser model:
  - exactly three tx_en pulses, in order;
  - each pulse occurs only after tx_status has gone 0 then 1;
  - UART_TX frames decode to 11, 22, 33.
- Hold tx_status=0 and push 17 bytes (DEPTH_LOG2=4):
  - full=1 and count=16 after the 16th push;
  - 17th byte dropped, overflow=1;
  - ovf_clr pulse -> overflow=0.
- FIFO full, push and pop on the same edge: push dropped, overflow=1, count=15, rd_ptr wraps correctly. Then drain: 16 bytes total out, in push order, across the pointer wrap.
- Assert reset while in WAIT_DONE with 5 bytes queued:
  - immediately count=0, tx_en=0, empty=1;
  - no tx_en after reset release until a new push.
- With UART_TX_FIFO_FLUSH_EN: queue 4 bytes, let the first pop, pulse flush:
  - count=0;
  - the in-flight byte still completes on UART_TX;
  - no further tx_en pulses.
